fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter SHALL be: TIMEOUT, 15, max REQ cycles without imem_ack before fault.
REQ-002 Port SHALL be: clk  input  1  sole clock, rising edge.
REQ-003 Port SHALL be: rstd  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: pc  input  32  fetch address from writeback stage.
REQ-005 Port SHALL be: pc_load  input  1  pc valid this cycle.
REQ-006 Port SHALL be: imem_req  output  1  instruction-memory request.
REQ-007 Port SHALL be: imem_addr  output  32  request address.
REQ-008 Port SHALL be: imem_ack  input  1  memory data valid.
REQ-009 Port SHALL be: imem_rdata  input  32  memory read data.
REQ-010 Port SHALL be: ins  output  32  fetched instruction to decode.
REQ-011 Port SHALL be: ins_pc  output  32  address of ins.
REQ-012 Port SHALL be: ins_valid  output  1  ins/ins_pc valid.
REQ-013 Port SHALL be: ins_ready  input  1  decode accepts ins.
REQ-014 Port SHALL be: fetch_busy  output  1  high in any state other than IDLE, or pending full.
REQ-015 Port SHALL be: fetch_fault  output  1  sticky error flag.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD; all outputs registered.
REQ-017 IDLE + pc_load with pc[1:0]==0 SHALL latch pc into imem_addr and enter REQ; imem_req high the cycle after the pc_load edge.
REQ-018 IDLE + pc_load with pc[1:0]!=0 SHALL set fetch_fault, issue no request, stay IDLE.
REQ-019 In REQ, imem_req SHALL stay high and imem_addr stable until imem_ack sampled high.
REQ-020 REQ + imem_ack SHALL capture imem_rdata into ins, imem_addr into ins_pc, drop imem_req, enter HOLD; ins_valid high the next cycle.
REQ-021 Timeout counter SHALL be 4 bits minimum, cleared on REQ entry, incremented each REQ cycle without ack; at count==TIMEOUT: set fetch_fault, drop imem_req, enter IDLE, discard pending.
REQ-022 In HOLD, ins_valid SHALL stay high and ins/ins_pc stable until ins_ready sampled high.
REQ-023 HOLD + ins_ready SHALL clear ins_valid; next state REQ if pending full or pc_load same cycle (pc_load wins over pending), else IDLE.
REQ-024 pc_load in REQ or HOLD SHALL write one-deep pending register; a later pc_load overwrites it (newest wins).
REQ-025 imem_ack outside REQ SHALL be ignored.
REQ-026 REQ + imem_ack + pc_load same cycle SHALL capture data and store pc as pending.
REQ-027 Misaligned pending address SHALL set fetch_fault when issued and be dropped, returning IDLE.
REQ-028 fetch_fault SHALL clear only on reset.
REQ-029 Minimum fetch latency SHALL be 2 cycles pc_load-to-ins_valid with zero-wait ack.

Reset
REQ-030 rstd low SHALL immediately force state IDLE, imem_req=0, imem_addr=0, ins=0, ins_pc=0, ins_valid=0, fetch_busy=0, fetch_fault=0, pending empty, counter 0, independent of clk.
REQ-031 Reset mid-REQ or mid-HOLD SHALL abort transaction; a late imem_ack after release SHALL be ignored.
REQ-032 First pc_load SHALL be accepted on the first rising edge after rstd rises.

Verification
REQ-033 pc_load pc=0x00000004, ack one cycle after req, ins_ready=1 -> ins=imem_rdata, ins_pc=0x00000004, ins_valid one cycle, fault=0.
REQ-034 pc=0x12345678 with ack delayed 5 cycles -> imem_req held 6 cycles, imem_addr constant 0x12345678, ins_valid after ack.
REQ-035 pc=0x87654321 -> fetch_fault=1, imem_req never asserted, fault persists through later valid fetches.
REQ-036 ack never given -> after 15 REQ cycles fetch_fault=1, imem_req=0, state IDLE.
REQ-037 ins_ready low 3 cycles, pc_load 0x00000010 then 0x00000020 during HOLD -> ins stable, next request address 0x00000020 only.
REQ-038 rstd pulsed low mid-REQ -> all outputs 0 asynchronously; stale ack ignored; fresh pc_load 0xfffffffc fetched normally.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word-aligned request at a time,
// holds the returned instruction for decode, and buffers one follow-on pc.
module fetch_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc,
    input  logic        pc_load,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        fetch_busy,
    output logic        fetch_fault
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        ins_q, ins_d;
    logic [31:0]        ins_pc_q, ins_pc_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic               pend_vld_q, pend_vld_d;
    logic [31:0]        pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        next_addr;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        cnt_d       = cnt_q;
        next_addr   = pc_load ? pc : pend_addr_q;

        unique case (state_q)
            IDLE: begin
                if (pc_load) begin
                    if (pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = pc;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (imem_ack) begin
                    ins_d    = imem_rdata;
                    ins_pc_d = addr_q;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = HOLD;
                    if (pc_load) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = pc;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last unacknowledged cycle: give up and drop any queued pc too.
                    fault_d    = 1'b1;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    pend_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (pc_load) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = pc;
                    end
                end
            end
            HOLD: begin
                if (ins_ready) begin
                    valid_d    = 1'b0;
                    pend_vld_d = 1'b0;
                    // A same-cycle pc_load takes priority over the buffered pc.
                    if (pc_load || pend_vld_q) begin
                        if (next_addr[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            addr_d  = next_addr;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pc_load) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = pc;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE) || pend_vld_d;
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign ins         = ins_q;
    assign ins_pc      = ins_pc_q;
    assign ins_valid   = valid_q;
    assign fetch_busy  = busy_q;
    assign fetch_fault = fault_q;

endmodule
